ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Single-clock arbiter that shares the fast-domain port of the dual-port data RAM between two requesters: requester 0 (CPU load/store unit) and requester 1 (JPEG bitstream/DMA writer). It decodes the shared address map, gates writes to unmapped addresses, and bounds each owner's tenure with a burst counter. It returns read data with a one-cycle registered response.

## Interface
- WIDTH, 32, data/address width
- MAX_BURST, 4, maximum consecutive beats per ownership (legal 1..15)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req0_i / req1_i  in  1  request valid, held until granted
- addr0_i / addr1_i  in  WIDTH  word address
- wdata0_i / wdata1_i  in  WIDTH  write data
- we0_i / we1_i  in  1  1 = write, 0 = read
- gnt0_o / gnt1_o  out  1  beat accepted this cycle
- rvalid0_o / rvalid1_o  out  1  response pulse
- rdata0_o / rdata1_o  out  WIDTH  read data
- err0_o / err1_o  out  1  unmapped address, valid with rvalid
- ram_addr_o  out  WIDTH  to RAM port
- ram_wdata_o  out  WIDTH  to RAM port
- ram_enw_o  out  1  to RAM port
- ram_rdata_i  in  WIDTH  combinational read data from RAM

## Operation
- Mapped addresses:
  - RAM_BASE = 206800 to RAM_BASE+1199
  - CTRL0 = 411698
  - CTRL1 = 411699
  - Everything else is unmapped.
- State machine: IDLE, OWN0, OWN1. The `last` register holds the previous owner. A 4-bit `beats` counter counts beats in the current tenure.
- Reset values:
  - State = IDLE, last = 1, beats = 0.
  - All outputs 0.
- IDLE:
  - No grant is issued in this state.
  - Exactly one req: next state is OWN of that requester.
  - Both req: next state is OWN of the requester ≠ last.
  - Neither req: stay in IDLE.
- OWNk with req_k = 1:
  - gnt_k = 1 combinationally.
  - ram_addr_o = addr_k and ram_wdata_o = wdata_k.
  - ram_enw_o = we_k AND mapped(addr_k).
  - beats increments.
- OWNk transitions, evaluated on beat outcome:
  - req_k = 0: go to OWN of the other requester if it is requesting, else IDLE. beats = 0, last = k.
  - Beat granted and beats+1 == MAX_BURST with the other requesting: go to OWN of the other requester. beats = 0, last = k.
  - Beat granted otherwise: stay in OWNk. A burst is not cut when the other requester is idle; beats saturates at MAX_BURST.
- Ownership hands over directly from OWN to OWN, with no IDLE bubble.
- When no grant is issued:
  - ram_addr_o and ram_wdata_o = 0.
  - ram_enw_o = 0.
- Response for every granted beat:
  - The cycle after the grant, rvalid_k pulses for 1 cycle.
  - Read: rdata_k = ram_rdata_i sampled in the grant cycle.
  - Write: rdata_k = 0.
  - err_k = !mapped(addr_k).
  - rdata and err hold their values until the next response.
- Unmapped write: RAM is not written, err_k = 1. Unmapped read: rdata = 0, err_k = 1.
- gnt0_o and gnt1_o are never both 1 in the same cycle.
- rst asserted mid-burst: all state and outputs return to reset values immediately. A pending rvalid is dropped.

## Timing
- Request latency:
  - req rising at edge t while in IDLE: grant in cycle t+1.
  - Response in cycle t+2.
- Back-to-back beats: while holding ownership, the owner gets 1 beat per cycle.
- Worst-case wait for a requester under contention: MAX_BURST + 1 cycles.
- Address decode uses full-width unsigned compare. The subtraction addr − RAM_BASE must not wrap: addresses below RAM_BASE are unmapped.
- Requester rules:
  - addr, wdata and we must be held stable while req = 1 and gnt = 0.
  - Dropping req without a grant is legal and loses nothing.

## Structure
- Package ram_map_pkg holds:
  - RAM_BASE, RAM_DEPTH = 1200, CTRL0_ADDR, CTRL1_ADDR.
  - The owner_e enum {IDLE, OWN0, OWN1}.
  - The mapped() function.
- The dual-port RAM and the CPU should use the same package for address constants.
- One sub-module: ram_addr_decode, a combinational mapped/unmapped check instantiated once per requester. All other logic stays in ram_port_arbiter.

## Test plan
- Single read: req0, addr 206800, RAM holds 0xDEADBEEF.
  - Expect gnt0 at t+1, rvalid0 at t+2 with rdata0 = 0xDEADBEEF, err0 = 0.
- Simultaneous req0/req1 after reset.
  - Expect OWN0 first (last = 1).
  - With MAX_BURST = 4 and both held: 4 gnt0, then 4 gnt1, alternating, no idle cycle.
- Lone owner: req1 continuously with req0 = 0 for 10 beats.
  - Expect 10 consecutive gnt1; ownership is never released.
- Unmapped write: req0 write to addr 300000.
  - Expect ram_enw_o = 0, rvalid0 = 1 with err0 = 1.
- Control write: write to 411698 data 0x1 via req1.
  - Expect ram_enw_o = 1 and ram_addr_o = 411698 in the grant cycle, err1 = 0.
- Reset mid-burst: rst asserted during the second beat of OWN0.
  - Expect all outputs 0 and no rvalid afterwards.
  - Next request re-arbitrates from IDLE.

Source files
------------

// File: rtl/ram_map_pkg.sv
// Shared address map of the fast-domain data RAM port: base, depth, control
// registers, arbiter owner encoding and the mapped-address predicate.
package ram_map_pkg;

  localparam logic [63:0] RAM_BASE   = 64'd206800;
  localparam logic [63:0] RAM_DEPTH  = 64'd1200;
  localparam logic [63:0] CTRL0_ADDR = 64'd411698;
  localparam logic [63:0] CTRL1_ADDR = 64'd411699;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_e;

  // The base check comes first so addresses below RAM_BASE never reach the
  // subtraction; an address below the base would otherwise wrap around.
  function automatic logic mapped(input logic [63:0] addr);
    logic in_ram;
    in_ram = (addr >= RAM_BASE) && ((addr - RAM_BASE) < RAM_DEPTH);
    return in_ram || (addr == CTRL0_ADDR) || (addr == CTRL1_ADDR);
  endfunction

endpackage

// File: rtl/ram_addr_decode.sv
// Combinational mapped/unmapped check for one requester's word address.
module ram_addr_decode
  import ram_map_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] addr,
  output logic             hit
);

  logic [63:0] addr_ext;

  assign addr_ext = 64'(addr);
  assign hit      = mapped(addr_ext);

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for the fast-domain RAM port with burst-bounded
// tenure, write gating on unmapped addresses and a one-cycle read response.
module ram_port_arbiter
  import ram_map_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_i,
  input  logic [WIDTH-1:0] addr0_i,
  input  logic [WIDTH-1:0] wdata0_i,
  input  logic             we0_i,
  input  logic             req1_i,
  input  logic [WIDTH-1:0] addr1_i,
  input  logic [WIDTH-1:0] wdata1_i,
  input  logic             we1_i,
  output logic             gnt0_o,
  output logic             gnt1_o,
  output logic             rvalid0_o,
  output logic             rvalid1_o,
  output logic [WIDTH-1:0] rdata0_o,
  output logic [WIDTH-1:0] rdata1_o,
  output logic             err0_o,
  output logic             err1_o,
  output logic [WIDTH-1:0] ram_addr_o,
  output logic [WIDTH-1:0] ram_wdata_o,
  output logic             ram_enw_o,
  input  logic [WIDTH-1:0] ram_rdata_i,
  output owner_e           dbg_state
);

  localparam logic [3:0] MAX_B4 = 4'(MAX_BURST);
  localparam logic [4:0] MAX_B5 = 5'(MAX_BURST);

  owner_e     state;
  logic       last_owner;
  logic [3:0] beats;
  logic       hit0;
  logic       hit1;
  logic       gnt0;
  logic       gnt1;
  logic       burst_done;

  ram_addr_decode #(.WIDTH(WIDTH)) u_dec0 (.addr(addr0_i), .hit(hit0));
  ram_addr_decode #(.WIDTH(WIDTH)) u_dec1 (.addr(addr1_i), .hit(hit1));

  // Handshake: a beat transfers in every cycle where req_k and gnt_k are both
  // high. While req_k is high without gnt_k the requester holds addr/wdata/we;
  // it may drop req_k before a grant without side effects.
  assign gnt0 = (state == OWN0) && req0_i;
  assign gnt1 = (state == OWN1) && req1_i;

  assign gnt0_o    = gnt0;
  assign gnt1_o    = gnt1;
  assign dbg_state = state;

  // ">=" rather than "==" so a lone owner whose count has saturated still
  // yields on the next beat once the other side starts requesting.
  assign burst_done = ({1'b0, beats} + 5'd1) >= MAX_B5;

  always_comb begin
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_enw_o   = 1'b0;
    if (gnt0) begin
      ram_addr_o  = addr0_i;
      ram_wdata_o = wdata0_i;
      ram_enw_o   = we0_i && hit0;
    end else if (gnt1) begin
      ram_addr_o  = addr1_i;
      ram_wdata_o = wdata1_i;
      ram_enw_o   = we1_i && hit1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      beats      <= '0;
      rvalid0_o  <= 1'b0;
      rvalid1_o  <= 1'b0;
      rdata0_o   <= '0;
      rdata1_o   <= '0;
      err0_o     <= 1'b0;
      err1_o     <= 1'b0;
    end else begin
      rvalid0_o <= gnt0;
      rvalid1_o <= gnt1;
      if (gnt0) begin
        rdata0_o <= (we0_i || !hit0) ? '0 : ram_rdata_i;
        err0_o   <= !hit0;
      end
      if (gnt1) begin
        rdata1_o <= (we1_i || !hit1) ? '0 : ram_rdata_i;
        err1_o   <= !hit1;
      end

      case (state)
        IDLE: begin
          if (req0_i && req1_i) begin
            state <= last_owner ? OWN0 : OWN1;
          end else if (req0_i) begin
            state <= OWN0;
          end else if (req1_i) begin
            state <= OWN1;
          end
        end
        OWN0: begin
          if (!req0_i) begin
            state      <= req1_i ? OWN1 : IDLE;
            beats      <= '0;
            last_owner <= 1'b0;
          end else if (burst_done && req1_i) begin
            state      <= OWN1;
            beats      <= '0;
            last_owner <= 1'b0;
          end else if (beats != MAX_B4) begin
            beats <= beats + 4'd1;
          end
        end
        OWN1: begin
          if (!req1_i) begin
            state      <= req0_i ? OWN0 : IDLE;
            beats      <= '0;
            last_owner <= 1'b1;
          end else if (burst_done && req0_i) begin
            state      <= OWN0;
            beats      <= '0;
            last_owner <= 1'b1;
          end else if (beats != MAX_B4) begin
            beats <= beats + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          beats <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM model, per-port response
// scoreboard and one task per scenario.
module tb_ram_port_arbiter;
  import ram_map_pkg::*;

  localparam int W    = 32;
  localparam int MAXB = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [W-1:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic         gnt0, gnt1, rvalid0, rvalid1, err0, err1, ram_enw;
  logic [W-1:0] rdata0, rdata1, ram_addr, ram_wdata, ram_rdata;
  owner_e       dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  // scoreboard: {err, rdata} expected for each granted beat
  logic [W:0] exp_q0[$];
  logic [W:0] exp_q1[$];
  logic       pend0 = 1'b0, pend1 = 1'b0;
  logic [W:0] mon_exp;

  logic [W-1:0] ram_mem [0:1199];
  logic [W-1:0] ctrl_reg [0:1];

  // last single-beat observations
  int           b_wait;
  logic         b_enw, b_rv, b_err;
  logic [W-1:0] b_addr, b_wdata, b_rd;

  ram_port_arbiter #(.WIDTH(W), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .req0_i(req0), .addr0_i(addr0), .wdata0_i(wdata0), .we0_i(we0),
    .req1_i(req1), .addr1_i(addr1), .wdata1_i(wdata1), .we1_i(we1),
    .gnt0_o(gnt0), .gnt1_o(gnt1),
    .rvalid0_o(rvalid0), .rvalid1_o(rvalid1),
    .rdata0_o(rdata0), .rdata1_o(rdata1),
    .err0_o(err0), .err1_o(err1),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_enw_o(ram_enw),
    .ram_rdata_i(ram_rdata),
    .dbg_state(dbg_state)
  );

  function automatic logic tb_mapped(input logic [W-1:0] a);
    return (a >= 32'd206800 && a <= 32'd207999) || a == 32'd411698 || a == 32'd411699;
  endfunction

  function automatic logic [W-1:0] ram_read(input logic [W-1:0] a);
    logic [10:0] idx;
    idx = 11'(a - 32'd206800);
    if (a >= 32'd206800 && a <= 32'd207999) return ram_mem[idx];
    else if (a == 32'd411698) return ctrl_reg[0];
    else if (a == 32'd411699) return ctrl_reg[1];
    else return 32'hBAD0_0000 ^ a;
  endfunction

  always_comb ram_rdata = ram_read(ram_addr);

  always @(posedge clk) begin
    logic [10:0] widx;
    widx = 11'(ram_addr - 32'd206800);
    if (ram_enw) begin
      if (ram_addr >= 32'd206800 && ram_addr <= 32'd207999) ram_mem[widx] = ram_wdata;
      else if (ram_addr == 32'd411698) ctrl_reg[0] = ram_wdata;
      else if (ram_addr == 32'd411699) ctrl_reg[1] = ram_wdata;
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      pend0 = 1'b0;
      pend1 = 1'b0;
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      tests_run++;
      if (gnt0 && gnt1) begin
        tests_failed++;
        $display("FAIL gnt_mutex: gnt0=%b gnt1=%b, required not both", gnt0, gnt1);
      end
      if (pend0 || rvalid0) begin
        tests_run++;
        if (rvalid0 !== pend0 || exp_q0.size() == 0) begin
          tests_failed++;
          $display("FAIL rvalid0_timing: got %b, required %b", rvalid0, pend0);
        end else begin
          mon_exp = exp_q0.pop_front();
          if ({err0, rdata0} !== mon_exp) begin
            tests_failed++;
            $display("FAIL resp0: got err=%b rdata=%h, required err=%b rdata=%h",
                     err0, rdata0, mon_exp[W], mon_exp[W-1:0]);
          end
        end
      end
      if (pend1 || rvalid1) begin
        tests_run++;
        if (rvalid1 !== pend1 || exp_q1.size() == 0) begin
          tests_failed++;
          $display("FAIL rvalid1_timing: got %b, required %b", rvalid1, pend1);
        end else begin
          mon_exp = exp_q1.pop_front();
          if ({err1, rdata1} !== mon_exp) begin
            tests_failed++;
            $display("FAIL resp1: got err=%b rdata=%h, required err=%b rdata=%h",
                     err1, rdata1, mon_exp[W], mon_exp[W-1:0]);
          end
        end
      end
      pend0 = gnt0;
      pend1 = gnt1;
      if (gnt0) exp_q0.push_back({!tb_mapped(addr0), (we0 || !tb_mapped(addr0)) ? 32'h0 : ram_read(addr0)});
      if (gnt1) exp_q1.push_back({!tb_mapped(addr1), (we1 || !tb_mapped(addr1)) ? 32'h0 : ram_read(addr1)});
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_beat(input bit port, input logic [W-1:0] a, input logic we,
                          input logic [W-1:0] d);
    if (port) begin req1 = 1'b1; addr1 = a; we1 = we; wdata1 = d; end
    else      begin req0 = 1'b1; addr0 = a; we0 = we; wdata0 = d; end
    b_wait = 0;
    do begin
      @(negedge clk);
      b_wait++;
    end while (!(port ? gnt1 : gnt0) && b_wait < 8);
    b_enw   = ram_enw;
    b_addr  = ram_addr;
    b_wdata = ram_wdata;
    @(posedge clk); #1;
    if (port) req1 = 1'b0; else req0 = 1'b0;
    @(negedge clk);
    b_rv  = port ? rvalid1 : rvalid0;
    b_rd  = port ? rdata1  : rdata0;
    b_err = port ? err1    : err0;
    step(1);
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    step(2);
    @(negedge clk);
    tests_run++;
    if ({gnt0, gnt1, rvalid0, rvalid1, err0, err1, ram_enw} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b, required 0000000",
               {gnt0, gnt1, rvalid0, rvalid1, err0, err1, ram_enw});
    end
    tests_run++;
    if ({rdata0, rdata1, ram_addr, ram_wdata} !== 128'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h %h %h %h, required zeros", rdata0, rdata1, ram_addr, ram_wdata);
    end
    tests_run++;
    if (dbg_state !== IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d, required %0d", int'(dbg_state), int'(IDLE));
    end
    step(1);
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_single_read();
    ram_mem[0] = 32'hDEADBEEF;
    run_beat(1'b0, 32'd206800, 1'b0, $urandom);
    tests_run++;
    if (b_wait !== 2) begin
      tests_failed++;
      $display("FAIL read_latency: got %0d cycles, required 2", b_wait);
    end
    tests_run++;
    if (b_addr !== 32'd206800 || b_enw !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_bus: got addr=%0d enw=%b, required addr=206800 enw=0", b_addr, b_enw);
    end
    tests_run++;
    if (b_rv !== 1'b1 || b_rd !== 32'hDEADBEEF || b_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_resp: got rv=%b rdata=%h err=%b, required 1 deadbeef 0", b_rv, b_rd, b_err);
    end
  endtask

  task automatic test_arbitration();
    logic [1:0] exp_g;
    rst = 1'b1; step(1); rst = 1'b0; step(1);
    req0 = 1'b1; addr0 = 32'd206900; we0 = 1'b0;
    req1 = 1'b1; addr1 = 32'd207000; we1 = 1'b0;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      exp_g = (k == 0) ? 2'b00 : ((((k - 1) / MAXB) % 2 == 0) ? 2'b01 : 2'b10);
      tests_run++;
      if ({gnt1, gnt0} !== exp_g) begin
        tests_failed++;
        $display("FAIL arb_cycle%0d: got gnt1,gnt0=%b, required %b", k, {gnt1, gnt0}, exp_g);
      end
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    step(2);
  endtask

  task automatic test_lone_owner();
    int  c;
    bit  got;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd207100;
    @(negedge clk);
    tests_run++;
    if (gnt1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL lone_idle: got gnt1=%b, required 0", gnt1);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests_run++;
      if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
        tests_failed++;
        $display("FAIL lone_beat%0d: got gnt1=%b gnt0=%b, required 1 0", i, gnt1, gnt0);
      end
      @(posedge clk); #1;
      addr1 = 32'd207101 + 32'(i);
    end
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd206840;
    c = 0; got = 1'b0;
    while (!got && c < MAXB + 1) begin
      @(negedge clk);
      c++;
      if (gnt0) got = 1'b1;
    end
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL lone_handover: got no gnt0 in %0d cycles, required within %0d", c, MAXB + 1);
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    step(2);
  endtask

  task automatic test_unmapped();
    logic [W-1:0] tab_addr [0:4];
    logic         tab_err  [0:4];
    logic [W-1:0] exp_rd;
    tab_addr[0] = 32'd206799;     tab_err[0] = 1'b1;
    tab_addr[1] = 32'd207999;     tab_err[1] = 1'b0;
    tab_addr[2] = 32'd208000;     tab_err[2] = 1'b1;
    tab_addr[3] = 32'd411699;     tab_err[3] = 1'b0;
    tab_addr[4] = 32'hFFFF_FFFF;  tab_err[4] = 1'b1;

    run_beat(1'b0, 32'd300000, 1'b1, $urandom);
    tests_run++;
    if (b_enw !== 1'b0 || b_rv !== 1'b1 || b_err !== 1'b1 || b_rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL unmapped_write: got enw=%b rv=%b err=%b rdata=%h, required 0 1 1 0",
               b_enw, b_rv, b_err, b_rd);
    end
    for (int i = 0; i < 5; i++) begin
      exp_rd = tab_err[i] ? 32'h0 : ram_read(tab_addr[i]);
      run_beat(1'b1, tab_addr[i], 1'b0, '0);
      tests_run++;
      if (b_err !== tab_err[i] || b_rd !== exp_rd) begin
        tests_failed++;
        $display("FAIL decode_read%0d: got err=%b rdata=%h, required err=%b rdata=%h",
                 i, b_err, b_rd, tab_err[i], exp_rd);
      end
      run_beat(1'b0, tab_addr[i], 1'b1, $urandom);
      tests_run++;
      if (b_enw !== !tab_err[i] || b_err !== tab_err[i]) begin
        tests_failed++;
        $display("FAIL decode_write%0d: got enw=%b err=%b, required enw=%b err=%b",
                 i, b_enw, b_err, !tab_err[i], tab_err[i]);
      end
    end
  endtask

  task automatic test_ctrl_write();
    logic [W-1:0] rnd;
    run_beat(1'b1, 32'd411698, 1'b1, 32'h1);
    tests_run++;
    if (b_enw !== 1'b1 || b_addr !== 32'd411698 || b_wdata !== 32'h1) begin
      tests_failed++;
      $display("FAIL ctrl_write_bus: got enw=%b addr=%0d wdata=%h, required 1 411698 1",
               b_enw, b_addr, b_wdata);
    end
    tests_run++;
    if (b_rv !== 1'b1 || b_err !== 1'b0 || b_rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL ctrl_write_resp: got rv=%b err=%b rdata=%h, required 1 0 0", b_rv, b_err, b_rd);
    end
    run_beat(1'b0, 32'd411698, 1'b0, '0);
    tests_run++;
    if (b_rd !== 32'h1 || b_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL ctrl_readback: got rdata=%h err=%b, required 1 0", b_rd, b_err);
    end
    rnd = $urandom;
    run_beat(1'b0, 32'd207500, 1'b1, rnd);
    run_beat(1'b1, 32'd207500, 1'b0, '0);
    tests_run++;
    if (b_rd !== rnd) begin
      tests_failed++;
      $display("FAIL ram_readback: got %h, required %h", b_rd, rnd);
    end
  endtask

  task automatic test_reset_mid_burst();
    run_beat(1'b0, 32'd206820, 1'b0, '0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd206830;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (gnt0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL midburst_beat2: got gnt0=%b, required 1", gnt0);
    end
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if ({gnt0, gnt1, rvalid0, rvalid1, err0, err1, ram_enw} !== 7'b0 ||
        {rdata0, rdata1, ram_addr, ram_wdata} !== 128'h0 || dbg_state !== IDLE) begin
      tests_failed++;
      $display("FAIL midburst_reset: got ctrl=%b state=%0d, required zeros and IDLE",
               {gnt0, gnt1, rvalid0, rvalid1, err0, err1, ram_enw}, int'(dbg_state));
    end
    req0 = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL midburst_no_rvalid: got rvalid0=%b rvalid1=%b, required 0 0", rvalid0, rvalid1);
    end
    @(posedge clk); #1;
    req0 = 1'b1; addr0 = 32'd206850; we0 = 1'b0;
    req1 = 1'b1; addr1 = 32'd206860; we1 = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({gnt1, gnt0} !== 2'b00) begin
      tests_failed++;
      $display("FAIL rearb_idle: got gnt1,gnt0=%b, required 00", {gnt1, gnt0});
    end
    @(negedge clk);
    tests_run++;
    if ({gnt1, gnt0} !== 2'b01) begin
      tests_failed++;
      $display("FAIL rearb_first: got gnt1,gnt0=%b, required 01", {gnt1, gnt0});
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    step(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1200; i++) ram_mem[i] = $urandom;
    ctrl_reg[0] = '0;
    ctrl_reg[1] = '0;
    test_reset();
    test_single_read();
    test_arbitration();
    test_lone_owner();
    test_unmapped();
    test_ctrl_write();
    test_reset_mid_burst();
    tests_run++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_drain: got %0d/%0d outstanding, required 0/0", exp_q0.size(), exp_q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
